// File: rtl/axis_pkg.sv
// Shared helpers for the AXI-stream byte packer: width math, tkeep constants,
// low-aligned masks and byte counting.
package axis_pkg;

  localparam int MAX_BW = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Mask with the low k bits set, saturating at MAX_BW.
  function automatic logic [MAX_BW-1:0] low_mask(input int k);
    logic [MAX_BW-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BW; i++) begin
      if (i < k) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [MAX_BW-1:0] tkeep_all_one(input int bw);
    return low_mask(bw);
  endfunction

  function automatic logic [MAX_BW-1:0] tkeep_all_zero();
    return '0;
  endfunction

  function automatic int popcount(input logic [MAX_BW-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < MAX_BW; i++) r = r + 32'(v[i]);
    return r;
  endfunction

endpackage

// File: rtl/axi_stream_packer_if.sv
// AXI-stream bundle for the packer. A beat transfers on a rising clock edge
// where tvalid && tready; once raised, tvalid and payload hold until that edge.
interface axi_stream_packer_if #(parameter int BW = 4);
  logic            tvalid;
  logic            tready;
  logic [8*BW-1:0] tdata;
  logic [BW-1:0]   tkeep;
  logic            tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_byte_compact.sv
// Combinational compaction of kept bytes into ascending low positions.
// Unused upper bytes of packed_data are zero.
module axis_byte_compact
  import axis_pkg::*;
#(
  parameter int BW = 4
) (
  input  logic [8*BW-1:0]          data,
  input  logic [BW-1:0]            keep,
  output logic [8*BW-1:0]          packed_data,
  output logic [clog2(BW+1)-1:0]   n
);

  int pos;

  // Running prefix count of kept bytes gives each byte its destination slot.
  always_comb begin
    packed_data = '0;
    pos = 0;
    for (int k = 0; k < BW; k++) begin
      if (keep[k]) begin
        packed_data[8*pos +: 8] = data[8*k +: 8];
        pos = pos + 1;
      end
    end
  end

  assign n = ($bits(n))'(popcount(MAX_BW'(keep)));

endmodule

// File: rtl/axi_stream_packer.sv
// Removes null bytes from a sparse-tkeep AXI stream and re-emits packed beats.
// Build option AXIS_PACKER_ZERO_FILL_EN forces unkept output bytes to 8'h00.
module axi_stream_packer
  import axis_pkg::*;
#(
  parameter int BW = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  axi_stream_packer_if.slave   i_axis,
  axi_stream_packer_if.master  o_axis
);

  localparam int BB = 2 * BW;
  localparam int CW = clog2(BB + 1);
  localparam int NW = clog2(BW + 1);
  localparam logic [CW-1:0] BW_C = CW'(BW);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic [8*BB-1:0] buf_q, buf_d;
  logic [8*BB-1:0] shifted, low_bytes;
  logic [CW-1:0]   pop_n, add_n, base;
  logic [8*BW-1:0] comp_data;
  logic [NW-1:0]   comp_n;
  logic            push, pop, full;
  logic [BW-1:0]   keep;

  axis_byte_compact #(.BW(BW)) u_compact (
    .data        (i_axis.tdata),
    .keep        (i_axis.tkeep),
    .packed_data (comp_data),
    .n           (comp_n)
  );

  assign full = cnt_q >= BW_C;

  // Ready depends only on registered state, so no path from o_tready or i_tvalid.
  assign i_axis.tready = rstn && (cnt_q <= BW_C) && !last_q;
  assign push = i_axis.tvalid && i_axis.tready;

  assign o_axis.tvalid = full || (last_q && (cnt_q != '0));
  assign o_axis.tlast  = last_q && (cnt_q <= BW_C);
  assign pop = o_axis.tvalid && o_axis.tready;

  always_comb begin
    keep = full ? BW'(tkeep_all_one(BW)) : BW'(low_mask(int'(cnt_q)));
  end
  assign o_axis.tkeep = keep;

`ifdef AXIS_PACKER_ZERO_FILL_EN
  always_comb begin
    o_axis.tdata = '0;
    for (int k = 0; k < BW; k++) begin
      if (keep[k]) o_axis.tdata[8*k +: 8] = buf_q[8*k +: 8];
    end
  end
`else
  assign o_axis.tdata = buf_q[8*BW-1:0];
`endif

  // Pop shifts the buffer down first; new bytes land right after the survivors.
  always_comb begin
    pop_n = pop ? (full ? BW_C : cnt_q) : '0;
    add_n = push ? CW'(comp_n) : '0;
    base  = cnt_q - pop_n;
    cnt_d = base + add_n;

    shifted   = buf_q >> {pop_n, 3'b000};
    low_bytes = '0;
    for (int k = 0; k < BB; k++) begin
      if (k < int'(base)) low_bytes[8*k +: 8] = 8'hFF;
    end
    buf_d = shifted & low_bytes;
    if (push) buf_d = buf_d | ({{(8*BW){1'b0}}, comp_data} << {base, 3'b000});

    last_d = last_q;
    if (pop && o_axis.tlast) last_d = 1'b0;
    // A last beat that leaves nothing buffered has no beat to carry tlast.
    if (push && i_axis.tlast && (cnt_d != '0)) last_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      buf_q  <= buf_d;
    end
  end

endmodule

// File: tb/tb_axi_stream_packer.sv
// Bench for axi_stream_packer: directed scenarios plus random traffic checked
// against a packet-level byte-queue model.
module tb_axi_stream_packer;

  localparam int BW = 4;
  localparam int DW = 8 * BW;
  localparam int EW = DW + BW + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_stream_packer_if #(.BW(BW)) in_if ();
  axi_stream_packer_if #(.BW(BW)) out_if ();

  axi_stream_packer #(.BW(BW)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .i_axis (in_if),
    .o_axis (out_if)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bp_mode = 2;
  int pkt_bytes = 0;

  logic [7:0]    cur_q[$];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  int            pop_cyc_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mask_bytes(input logic [DW-1:0] d, input logic [BW-1:0] k);
    for (int j = 0; j < BW; j++) begin
      if (!k[j]) d[8*j +: 8] = 8'h00;
    end
    return d;
  endfunction

  // Pop nb bytes from the current packet into one expected output beat.
  task automatic emit(input logic last, input int nb);
    logic [DW-1:0] d;
    logic [BW-1:0] k;
    d = '0;
    k = '0;
    for (int j = 0; j < nb; j++) begin
      d[8*j +: 8] = cur_q.pop_front();
      k[j] = 1'b1;
    end
    exp_q.push_back({last, k, d});
  endtask

  // Packet view: kept bytes join the packet; full beats leave in BW chunks,
  // and the packet tail leaves as a low-aligned last beat.
  task automatic model_push(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic last);
    for (int j = 0; j < BW; j++) begin
      if (k[j]) begin
        cur_q.push_back(d[8*j +: 8]);
        pkt_bytes++;
      end
    end
    if (!last) begin
      while (cur_q.size() >= BW) emit(1'b0, BW);
    end else begin
      while (cur_q.size() > BW) emit(1'b0, BW);
      if (cur_q.size() > 0) emit(1'b1, cur_q.size());
      pkt_bytes = 0;
    end
  endtask

  initial begin
    out_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_if.tready = 1'b1;
        1:       out_if.tready = ($urandom_range(0, 9) < 7);
        default: out_if.tready = 1'b0;
      endcase
    end
  end

  // Monitor/scoreboard: sampled at the falling edge, where handshakes are settled.
  initial begin
    logic [EW-1:0] e;
    logic [DW-1:0] got_d;
    forever begin
      @(negedge clk);
      cyc++;
      if (rstn) begin
        if (out_if.tvalid) begin
`ifdef AXIS_PACKER_ZERO_FILL_EN
          got_d = out_if.tdata;
`else
          got_d = mask_bytes(out_if.tdata, out_if.tkeep);
`endif
          if (exp_q.size() == 0) begin
            check("spurious_valid", 64'(out_if.tvalid), 64'd0);
          end else begin
            e = exp_q[0];
            check("o_tkeep", 64'(out_if.tkeep), 64'(e[DW +: BW]));
            check("o_tlast", 64'(out_if.tlast), 64'(e[EW-1]));
            check("o_tdata", 64'(got_d), 64'(e[DW-1:0]));
            if (out_if.tready) begin
              exp_q.delete(0);
              got_q.push_back({out_if.tlast, out_if.tkeep, got_d});
              pop_cyc_q.push_back(cyc);
            end
          end
        end
        if (in_if.tvalid && in_if.tready) model_push(in_if.tdata, in_if.tkeep, in_if.tlast);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Called and returning at posedge+1.
  task automatic send_beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic last);
    int waits;
    waits = 0;
    in_if.tvalid = 1'b1;
    in_if.tdata  = d;
    in_if.tkeep  = k;
    in_if.tlast  = last;
    @(negedge clk);
    while (!in_if.tready && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (!in_if.tready) check("in_ready_timeout", 64'(in_if.tready), 64'd1);
    @(posedge clk);
    #1;
    in_if.tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
    idle(3);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [BW-1:0] k;
    logic          l;
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tkeep  = '0;
    in_if.tlast  = 1'b0;

    // Reset state
    #2;
    check("rst_o_tvalid", 64'(out_if.tvalid), 64'd0);
    check("rst_i_tready", 64'(in_if.tready), 64'd0);
    check("rst_o_tkeep", 64'(out_if.tkeep), 64'd0);
    check("rst_o_tlast", 64'(out_if.tlast), 64'd0);
    check("rst_o_tdata", 64'(out_if.tdata), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_i_tready", 64'(in_if.tready), 64'd1);

    // Dense stream, back to back
    bp_mode = 0;
    idle(2);
    got_q.delete();
    pop_cyc_q.delete();
    send_beat(32'h03020100, 4'hF, 1'b0);
    send_beat(32'h07060504, 4'hF, 1'b1);
    drain();
    check("dense_count", 64'(got_q.size()), 64'd2);
    check("dense_b0", 64'(got_q[0]), 64'({1'b0, 4'hF, 32'h03020100}));
    check("dense_b1", 64'(got_q[1]), 64'({1'b1, 4'hF, 32'h07060504}));
    check("dense_gap", 64'(pop_cyc_q[1] - pop_cyc_q[0]), 64'd1);

    // Sparse keeps merge into one beat
    got_q.delete();
    send_beat(32'hDDCCBBAA, 4'b0101, 1'b0);
    send_beat(32'h44332211, 4'b1010, 1'b1);
    drain();
    check("sparse_count", 64'(got_q.size()), 64'd1);
    check("sparse_b0", 64'(got_q[0]), 64'({1'b1, 4'hF, 32'h4422CCAA}));

    // Overflow at last
    got_q.delete();
    send_beat(32'h00CCBBAA, 4'b0111, 1'b0);
    send_beat(32'h44332211, 4'hF, 1'b1);
    drain();
    check("ovf_count", 64'(got_q.size()), 64'd2);
    check("ovf_b0", 64'(got_q[0]), 64'({1'b0, 4'hF, 32'h11CCBBAA}));
    check("ovf_b1", 64'(got_q[1]), 64'({1'b1, 4'b0111, 32'h00443322}));

    // Empty beats absorbed; lone empty last dropped
    got_q.delete();
    send_beat(32'hDEADBEEF, 4'h0, 1'b0);
    send_beat(32'h00002211, 4'b0011, 1'b0);
    send_beat(32'h12345678, 4'h0, 1'b0);
    send_beat(32'h00004433, 4'b0011, 1'b1);
    drain();
    check("empty_mix", 64'(got_q[0]), 64'({1'b1, 4'hF, 32'h44332211}));
    got_q.delete();
    send_beat(32'hCAFEF00D, 4'h0, 1'b1);
    idle(5);
    check("empty_last_ready", 64'(in_if.tready), 64'd1);
    check("empty_last_novalid", 64'(out_if.tvalid), 64'd0);
    check("empty_last_nobeat", 64'(got_q.size()), 64'd0);

    // Backpressure
    bp_mode = 2;
    idle(2);
    send_beat(32'h0D0C0B0A, 4'hF, 1'b0);
    check("bp_ready_at_bw", 64'(in_if.tready), 64'd1);
    send_beat(32'h000000EE, 4'b0001, 1'b0);
    check("bp_ready_fall", 64'(in_if.tready), 64'd0);
    for (int c = 0; c < 5; c++) begin
      idle(1);
      check("bp_valid", 64'(out_if.tvalid), 64'd1);
      check("bp_data", 64'(out_if.tdata), 64'h0D0C0B0A);
      check("bp_keep", 64'(out_if.tkeep), 64'hF);
      check("bp_last", 64'(out_if.tlast), 64'd0);
      check("bp_ready_low", 64'(in_if.tready), 64'd0);
    end
    got_q.delete();
    bp_mode = 0;
    send_beat(32'h0000FF11, 4'b0011, 1'b1);
    drain();
    check("bp_count", 64'(got_q.size()), 64'd2);
    check("bp_b0", 64'(got_q[0]), 64'({1'b0, 4'hF, 32'h0D0C0B0A}));
    check("bp_b1", 64'(got_q[1]), 64'({1'b1, 4'b0111, 32'h00FF11EE}));

    // Reset mid-packet
    bp_mode = 2;
    idle(2);
    send_beat(32'h0000BBAA, 4'b0011, 1'b1);
    check("mid_valid_before", 64'(out_if.tvalid), 64'd1);
    #2;
    rstn = 1'b0;
    exp_q.delete();
    cur_q.delete();
    pkt_bytes = 0;
    #1;
    check("mid_rst_valid", 64'(out_if.tvalid), 64'd0);
    check("mid_rst_ready", 64'(in_if.tready), 64'd0);
    check("mid_rst_keep", 64'(out_if.tkeep), 64'd0);
    check("mid_rst_last", 64'(out_if.tlast), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rstn = 1'b1;
    bp_mode = 0;
    idle(2);
    got_q.delete();
    send_beat(32'h0F0E0D0C, 4'hF, 1'b1);
    drain();
    check("post_rst_count", 64'(got_q.size()), 64'd1);
    check("post_rst_b0", 64'(got_q[0]), 64'({1'b1, 4'hF, 32'h0F0E0D0C}));

    // Random traffic against the packet model
    bp_mode = 1;
    for (int b = 0; b < 400; b++) begin
      d = DW'($urandom);
      l = ($urandom_range(0, 5) == 0);
      k = BW'($urandom_range(0, (1 << BW) - 1));
      if (l && k == '0 && pkt_bytes != 0) k = BW'($urandom_range(1, (1 << BW) - 1));
      send_beat(d, k, l);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    send_beat(DW'($urandom), 4'hF, 1'b1);
    bp_mode = 0;
    drain();
    check("final_ready", 64'(in_if.tready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
